fir_coef_ctrl: RTL and testbench
================================

Name: fir_coef_ctrl

Overview:
- Configuration controller for the decimating FIR.
- Parses a byte command stream from the FX2LP host interface.
- Loads filter coefficients into a shadow bank of a double-buffered coefficient store, and holds the gain setting.
- Atomically swaps coefficients, tap count and gain into the active set only at an FIR output boundary, so no output sample ever mixes old and new settings.

Parameters:
MAX_TAPS, 64, depth of each coefficient bank; legal tap counts are 1..MAX_TAPS
H_WIDTH, 16, coefficient width (signed)
ADDR_WIDTH, 6, coefficient address width; must satisfy 2^ADDR_WIDTH >= MAX_TAPS

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  asynchronous, active-high reset
cfg_data  in  8  command/payload byte from host
cfg_valid  in  1  cfg_data valid
cfg_ready  out  1  byte accepted when cfg_valid && cfg_ready
fir_boundary  in  1  one-cycle pulse: FIR has just emitted an output and cleared its accumulator
fir_idle  in  1  FIR not running; a swap is allowed without waiting for a boundary
coef_raddr  in  ADDR_WIDTH  FIR coefficient read address (tap index)
coef_rdata  out  H_WIDTH  active-bank coefficient, registered
num_taps  out  ADDR_WIDTH+1  active tap count
gain  out  5  active output gain shift
commit_pending  out  1  commit accepted, swap not yet done
swap_done  out  1  one-cycle pulse when the active set changes
cmd_err  out  1  one-cycle pulse on a protocol error

Behaviour:
- Reset values: coef_rdata=0, num_taps=0, gain=0, commit_pending=0, swap_done=0, cmd_err=0, cfg_ready=1, active bank=0, FSM=IDLE. Bank contents are not reset; num_taps=0 forces every read to return 0.
- Command framing: 0xA5 header, then a command byte.
  - 0x01 LOAD: LEN byte, then LEN coefficients, each sent as low byte then high byte.
  - 0x02 GAIN: one byte; bits[4:0] go to the shadow gain, bits[7:5] are ignored.
  - 0x03 COMMIT: no payload.
- FSM states: IDLE, CMD, LEN, COEF_LO, COEF_HI, GAIN_B.
  - IDLE: a byte other than 0xA5 is discarded silently. 0xA5 -> CMD.
  - CMD: 0x01 -> LEN. 0x02 -> GAIN_B. 0x03 -> set commit_pending, return to IDLE. Any other value -> cmd_err, IDLE.
  - LEN: a value of 0 or >MAX_TAPS -> cmd_err, IDLE. Otherwise latch the value as shadow_len, clear the write index, go to COEF_LO.
  - COEF_LO: latch the low byte -> COEF_HI.
  - COEF_HI: write {hi,lo} to shadow[index] in the same cycle. If index==shadow_len-1: set load_complete, go to IDLE. Otherwise increment index and go to COEF_LO.
  - GAIN_B: write the shadow gain -> IDLE.
- A new LOAD overwrites the shadow bank from address 0 and clears load_complete at the LEN byte. A partially loaded bank is never swapped in.
- cfg_ready=0 while commit_pending=1: the host stalls until the swap completes; no bytes are lost.
- Swap condition: commit_pending && (fir_boundary || fir_idle), evaluated from the cycle after the COMMIT byte is accepted. A boundary in the same cycle as COMMIT acceptance does not swap.
- Swap actions, all in one clock edge:
  - gain <= shadow gain.
  - If load_complete: toggle the active bank, num_taps <= shadow_len, clear load_complete. Otherwise the banks and num_taps are unchanged (gain-only commit).
  - Clear commit_pending; pulse swap_done.
- Read port: coef_rdata is valid 1 cycle after coef_raddr is presented. It always reads the active bank. If coef_raddr >= num_taps, coef_rdata=0. On the edge where a swap occurs, the next coef_rdata already reflects the new bank.
- Multiple COMMITs before a swap are idempotent.
- Reset mid-operation clears the FSM, commit_pending, load_complete and the active settings immediately (asynchronous reset).

Test Plan:
- Load 39 taps: A5 01 27, then bytes for 0x0029,0x0023,...,0x0029; then A5 03 with fir_idle=0. -> commit_pending=1, cfg_ready=0. After a fir_boundary pulse: swap_done once, num_taps=39. Reading addr 0 gives 0x0029 one cycle later; addr 19 gives 0x1000; addr 39 gives 0.
- A5 02 0x23 then A5 03 with fir_idle=1 -> gain=3 and swap_done on the second cycle after COMMIT acceptance; num_taps and coefficients unchanged.
- A5 01 00, and separately A5 01 41 (65) -> cmd_err pulse each time; the FSM returns to IDLE. A following A5 03 swaps gain only.
- A5 07 -> cmd_err. A stray 0x12 in IDLE -> no error; the next A5 03 is accepted normally.
- Partial load: A5 01 04 plus 3 coefficients, then the host stops. Sending A5 then arrives at COEF_LO as payload → word mis-framed. Then a full reset mid-load -> num_taps=0, all reads 0, cfg_ready=1.
- COMMIT with a fir_boundary in the same cycle -> no swap that cycle; the swap happens on the next boundary, 8 cycles later.

Source files
------------

// File: rtl/fir_coef_ctrl_if.sv
// Host command and FIR-side bus of the FIR coefficient controller.
// The master side (host plus FIR) drives the command bytes, the boundary/idle status and the read address.
interface fir_coef_ctrl_if #(
    parameter int H_WIDTH    = 16,
    parameter int ADDR_WIDTH = 6
);
    logic [7:0]            cfg_data;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic                  fir_boundary;
    logic                  fir_idle;
    logic [ADDR_WIDTH-1:0] coef_raddr;
    logic [H_WIDTH-1:0]    coef_rdata;
    logic [ADDR_WIDTH:0]   num_taps;
    logic [4:0]            gain;
    logic                  commit_pending;
    logic                  swap_done;
    logic                  cmd_err;

    modport master (
        output cfg_data, cfg_valid, fir_boundary, fir_idle, coef_raddr,
        input  cfg_ready, coef_rdata, num_taps, gain, commit_pending, swap_done, cmd_err
    );

    modport slave (
        input  cfg_data, cfg_valid, fir_boundary, fir_idle, coef_raddr,
        output cfg_ready, coef_rdata, num_taps, gain, commit_pending, swap_done, cmd_err
    );
endinterface

// File: rtl/fir_coef_ctrl.sv
// Parses host config bytes into a shadow coefficient bank and gain, and swaps them into the active set.
// The swap happens only at an FIR output boundary, or at any time while the FIR is idle.
//
// state   | meaning
// IDLE    | waiting for 0xA5 header; other bytes dropped
// CMD     | command byte expected
// LEN     | LOAD tap count expected
// COEF_LO | low byte of next coefficient expected
// COEF_HI | high byte expected; word written to shadow bank
// GAIN_B  | gain byte expected
module fir_coef_ctrl #(
    parameter int MAX_TAPS   = 64,
    parameter int H_WIDTH    = 16,
    parameter int ADDR_WIDTH = 6
) (
    input logic           clk,
    input logic           reset,
    fir_coef_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CMD, LEN, COEF_LO, COEF_HI, GAIN_B} state_t;

    localparam logic [7:0]            HDR       = 8'hA5;
    localparam logic [7:0]            OP_LOAD   = 8'h01;
    localparam logic [7:0]            OP_GAIN   = 8'h02;
    localparam logic [7:0]            OP_COMMIT = 8'h03;
    localparam logic [8:0]            MAX_LEN   = 9'(MAX_TAPS);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t state, state_nxt;

    logic [H_WIDTH-1:0]    mem [2][MAX_TAPS];
    logic                  active_bank;
    logic [ADDR_WIDTH:0]   shadow_len;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [7:0]            lo_byte;
    logic [4:0]            shadow_gain;
    logic                  load_complete;
    logic                  commit_pending;
    logic [ADDR_WIDTH:0]   num_taps;
    logic [4:0]            gain;
    logic [H_WIDTH-1:0]    coef_rdata;
    logic                  swap_done;
    logic                  cmd_err;

    logic accept, len_bad, wr_last, swap;
    logic lo_we, coef_we, len_seen, len_we, gain_we, commit_set, err, load_done;
    logic                  rd_bank;
    logic [ADDR_WIDTH:0]   rd_taps;

    assign bus.cfg_ready      = !commit_pending;
    assign bus.commit_pending = commit_pending;
    assign bus.num_taps       = num_taps;
    assign bus.gain           = gain;
    assign bus.coef_rdata     = coef_rdata;
    assign bus.swap_done      = swap_done;
    assign bus.cmd_err        = cmd_err;

    assign accept  = bus.cfg_valid && !commit_pending;
    assign len_bad = (bus.cfg_data == 8'h00) || ({1'b0, bus.cfg_data} > MAX_LEN);
    assign wr_last = ({1'b0, wr_idx} == (shadow_len - LEN_ONE));
    assign swap    = commit_pending && (bus.fir_boundary || bus.fir_idle);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        lo_we      = 1'b0;
        coef_we    = 1'b0;
        len_seen   = 1'b0;
        len_we     = 1'b0;
        gain_we    = 1'b0;
        commit_set = 1'b0;
        err        = 1'b0;
        load_done  = 1'b0;
        if (accept) begin
            case (state)
                IDLE: if (bus.cfg_data == HDR) state_nxt = CMD;
                CMD: begin
                    case (bus.cfg_data)
                        OP_LOAD:   state_nxt = LEN;
                        OP_GAIN:   state_nxt = GAIN_B;
                        OP_COMMIT: begin
                            commit_set = 1'b1;
                            state_nxt  = IDLE;
                        end
                        default: begin
                            err       = 1'b1;
                            state_nxt = IDLE;
                        end
                    endcase
                end
                LEN: begin
                    len_seen = 1'b1;
                    if (len_bad) begin
                        err       = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        len_we    = 1'b1;
                        state_nxt = COEF_LO;
                    end
                end
                COEF_LO: begin
                    lo_we     = 1'b1;
                    state_nxt = COEF_HI;
                end
                COEF_HI: begin
                    coef_we = 1'b1;
                    if (wr_last) begin
                        load_done = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = COEF_LO;
                    end
                end
                GAIN_B: begin
                    gain_we   = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Swap and commit can never coincide: commits are only accepted while nothing is pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_pending <= 1'b0;
            load_complete  <= 1'b0;
            shadow_len     <= '0;
            wr_idx         <= '0;
            lo_byte        <= '0;
            shadow_gain    <= '0;
            active_bank    <= 1'b0;
            num_taps       <= '0;
            gain           <= '0;
            swap_done      <= 1'b0;
            cmd_err        <= 1'b0;
        end else begin
            swap_done <= swap;
            cmd_err   <= err;
            if (lo_we)    lo_byte <= bus.cfg_data;
            if (len_seen) load_complete <= 1'b0;
            if (len_we) begin
                shadow_len <= bus.cfg_data[ADDR_WIDTH:0];
                wr_idx     <= '0;
            end
            if (coef_we && !wr_last) wr_idx <= wr_idx + IDX_ONE;
            if (load_done)  load_complete <= 1'b1;
            if (gain_we)    shadow_gain <= bus.cfg_data[4:0];
            if (commit_set) commit_pending <= 1'b1;
            if (swap) begin
                gain           <= shadow_gain;
                commit_pending <= 1'b0;
                if (load_complete) begin
                    active_bank   <= !active_bank;
                    num_taps      <= shadow_len;
                    load_complete <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (coef_we) mem[!active_bank][wr_idx] <= H_WIDTH'({bus.cfg_data, lo_byte});
    end

    // Read against the post-swap bank and tap count so the first read after a swap is already new.
    assign rd_bank = (swap && load_complete) ? !active_bank : active_bank;
    assign rd_taps = (swap && load_complete) ? shadow_len : num_taps;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) coef_rdata <= '0;
        else if ({1'b0, bus.coef_raddr} < rd_taps) coef_rdata <= mem[rd_bank][bus.coef_raddr];
        else coef_rdata <= '0;
    end
endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Scoreboard bench: stimulus pushes expected swaps, errors and reads; a negedge monitor pops and compares.
module tb_fir_coef_ctrl;
    localparam int MAX_TAPS = 64, H_WIDTH = 16, ADDR_WIDTH = 6;

    logic clk = 1'b0;
    logic reset;
    fir_coef_ctrl_if #(.H_WIDTH(H_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus();
    fir_coef_ctrl #(.MAX_TAPS(MAX_TAPS), .H_WIDTH(H_WIDTH), .ADDR_WIDTH(ADDR_WIDTH))
        dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {int cyc; int taps; int gain;} swap_t;
    swap_t        swap_q[$];
    int           err_q[$];
    logic [15:0]  rd_q[$];
    swap_t        se;
    int           ee;
    int           cyc = 0, acc = 0;
    int           total = 0, passed = 0;
    logic         rd_strobe = 1'b0, rd_vld_d = 1'b0;
    logic [15:0]  coef39 [39];

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rd_vld_d <= rd_strobe;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (bus.swap_done) begin
            if (swap_q.size() == 0) check("swap_unexpected", 32'(bus.swap_done), 0);
            else begin
                se = swap_q.pop_front();
                check("swap_cycle", cyc, se.cyc);
                check("swap_num_taps", 32'(bus.num_taps), se.taps);
                check("swap_gain", 32'(bus.gain), se.gain);
            end
        end
        if (bus.cmd_err) begin
            if (err_q.size() == 0) check("err_unexpected", 32'(bus.cmd_err), 0);
            else begin
                ee = err_q.pop_front();
                check("err_cycle", cyc, ee);
            end
        end
        if (rd_vld_d) begin
            if (rd_q.size() == 0) check("rd_unexpected", 32'(rd_vld_d), 0);
            else check("rd_data", 32'(bus.coef_rdata), 32'(rd_q.pop_front()));
        end
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        bus.cfg_data  = b;
        bus.cfg_valid = 1'b1;
        while (!bus.cfg_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("ready_timeout", 32'(bus.cfg_ready), 1);
        acc = cyc + 1;
        @(posedge clk);
        #1 bus.cfg_valid = 1'b0;
    endtask

    task automatic send_coef(input logic [15:0] c);
        send(c[7:0]);
        send(c[15:8]);
    endtask

    task automatic rd(input logic [5:0] a, input logic [15:0] e);
        @(negedge clk);
        bus.coef_raddr = a;
        rd_strobe      = 1'b1;
        rd_q.push_back(e);
        @(posedge clk);
        #1 rd_strobe = 1'b0;
    endtask

    task automatic push_swap(input int c, input int t, input int g);
        swap_t s;
        s.cyc = c; s.taps = t; s.gain = g;
        swap_q.push_back(s);
    endtask

    initial begin
        int k;
        bus.cfg_data = 8'h00; bus.cfg_valid = 1'b0; bus.fir_boundary = 1'b0;
        bus.fir_idle = 1'b0;  bus.coef_raddr = '0;  reset = 1'b1;
        for (int i = 0; i < 39; i++) begin
            k = (i < 19) ? i : 38 - i;
            coef39[i] = (k == 19) ? 16'h1000 : 16'(41 - 6 * k);
        end
        repeat (3) @(negedge clk);
        check("rst_coef_rdata", 32'(bus.coef_rdata), 0);
        check("rst_num_taps", 32'(bus.num_taps), 0);
        check("rst_gain", 32'(bus.gain), 0);
        check("rst_commit_pending", 32'(bus.commit_pending), 0);
        check("rst_swap_done", 32'(bus.swap_done), 0);
        check("rst_cmd_err", 32'(bus.cmd_err), 0);
        check("rst_cfg_ready", 32'(bus.cfg_ready), 1);
        reset = 1'b0;
        rd(6'd0, 16'h0000);

        // 39-tap load, committed while the FIR runs; swap on the boundary pulse
        send(8'hA5); send(8'h01); send(8'd39);
        for (int i = 0; i < 39; i++) send_coef(coef39[i]);
        send(8'hA5); send(8'h03);
        @(negedge clk);
        check("commit_pending_set", 32'(bus.commit_pending), 1);
        check("cfg_ready_stall", 32'(bus.cfg_ready), 0);
        repeat (3) @(negedge clk);
        bus.fir_boundary = 1'b1;
        bus.coef_raddr   = 6'd0;
        rd_strobe        = 1'b1;
        rd_q.push_back(16'h0029);
        push_swap(cyc + 1, 39, 0);
        @(posedge clk);
        #1 bus.fir_boundary = 1'b0; rd_strobe = 1'b0;
        rd(6'd19, 16'h1000); rd(6'd38, 16'h0029); rd(6'd1, 16'h0023);
        rd(6'd2, 16'h001D);  rd(6'd18, 16'hFFBD); rd(6'd39, 16'h0000);

        // gain-only commit with the FIR idle
        bus.fir_idle = 1'b1;
        send(8'hA5); send(8'h02); send(8'h23);
        send(8'hA5); send(8'h03);
        push_swap(acc + 1, 39, 3);
        repeat (2) @(negedge clk);
        rd(6'd19, 16'h1000); rd(6'd39, 16'h0000);

        // illegal lengths, then gain-only commit
        send(8'hA5); send(8'h01); send(8'h00); err_q.push_back(acc);
        send(8'hA5); send(8'h01); send(8'h41); err_q.push_back(acc);
        send(8'hA5); send(8'h02); send(8'h05);
        send(8'hA5); send(8'h03);
        push_swap(acc + 1, 39, 5);
        repeat (2) @(negedge clk);

        // unknown command, stray idle byte, then a clean commit
        send(8'hA5); send(8'h07); err_q.push_back(acc);
        send(8'h12);
        send(8'hA5); send(8'h03);
        push_swap(acc + 1, 39, 5);
        repeat (2) @(negedge clk);
        rd(6'd0, 16'h0029);

        // commit coinciding with a boundary: swap waits for the next boundary
        bus.fir_idle = 1'b0;
        send(8'hA5); send(8'h01); send(8'h03);
        send_coef(16'h1234); send_coef(16'h8001); send_coef(16'h00FF);
        send(8'hA5); send(8'h02); send(8'h1F);
        send(8'hA5);
        bus.fir_boundary = 1'b1;
        send(8'h03);
        bus.fir_boundary = 1'b0;
        push_swap(acc + 8, 3, 31);
        @(negedge clk);
        check("pending_after_same_cycle_boundary", 32'(bus.commit_pending), 1);
        while (cyc < acc + 7) @(negedge clk);
        bus.fir_boundary = 1'b1;
        @(posedge clk);
        #1 bus.fir_boundary = 1'b0;
        repeat (2) @(negedge clk);
        check("pending_cleared", 32'(bus.commit_pending), 0);
        check("ready_restored", 32'(bus.cfg_ready), 1);
        rd(6'd0, 16'h1234); rd(6'd1, 16'h8001); rd(6'd2, 16'h00FF);
        rd(6'd3, 16'h0000); rd(6'd19, 16'h0000);

        // partial load, mis-framed header, then asynchronous reset mid-load
        send(8'hA5); send(8'h01); send(8'h04);
        send_coef(16'h1111); send_coef(16'h2222); send_coef(16'h3333);
        send(8'hA5);
        @(negedge clk);
        check("partial_no_commit", 32'(bus.commit_pending), 0);
        #2 reset = 1'b1;
        #1;
        check("midrst_num_taps", 32'(bus.num_taps), 0);
        check("midrst_gain", 32'(bus.gain), 0);
        check("midrst_cfg_ready", 32'(bus.cfg_ready), 1);
        check("midrst_coef_rdata", 32'(bus.coef_rdata), 0);
        @(negedge clk);
        reset = 1'b0;
        rd(6'd0, 16'h0000); rd(6'd1, 16'h0000);
        bus.fir_idle = 1'b1;
        send(8'hA5); send(8'h03);
        push_swap(acc + 1, 0, 0);
        repeat (3) @(negedge clk);

        check("swap_queue_drained", swap_q.size(), 0);
        check("err_queue_drained", err_q.size(), 0);
        check("rd_queue_drained", rd_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
